// File: rtl/alarm_pkg.sv
// Shared types, BCD digit limits and increment helpers for the alarm clock core.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  localparam int SEC_LSB_MAX = 9;
  localparam int SEC_MSB_MAX = 5;
  localparam int HOUR24_MAX  = 23;
  localparam int HOUR12_MIN  = 1;
  localparam int HOUR12_MAX  = 12;

  // 12-hour mode powers up showing 12:00:00 AM
  localparam logic [3:0] RST12_HOUR_MSB = 4'd1;
  localparam logic [3:0] RST12_HOUR_LSB = 4'd2;

  // Two BCD digits plus a flag: wrap-out for sec/min, pm toggle for hours
  typedef struct packed {
    logic       carry;
    logic [3:0] msb;
    logic [3:0] lsb;
  } bcd_pair_t;

  // +1 on a 00..59 BCD field; carry set when it wraps to 00
  function automatic bcd_pair_t bcd_inc60(input logic [3:0] msb, input logic [3:0] lsb);
    bcd_pair_t r;
    r.carry = 1'b0;
    r.msb   = msb;
    r.lsb   = lsb + 4'd1;
    if (int'(lsb) == SEC_LSB_MAX) begin
      r.lsb = 4'd0;
      if (int'(msb) == SEC_MSB_MAX) begin
        r.msb   = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.msb = msb + 4'd1;
      end
    end
    return r;
  endfunction

  // +1 on the hour field; in 12h mode carry flags the 11->12 step (pm toggle)
  function automatic bcd_pair_t bcd_inc_hour(input logic h24, input logic [3:0] msb,
                                             input logic [3:0] lsb);
    bcd_pair_t r;
    int v;
    int n;
    v       = int'(msb) * 10 + int'(lsb);
    r.carry = 1'b0;
    if (h24) begin
      n = (v >= HOUR24_MAX) ? 0 : v + 1;
    end else begin
      n       = (v >= HOUR12_MAX) ? HOUR12_MIN : v + 1;
      r.carry = (v == HOUR12_MAX - 1);
    end
    r.msb = 4'(n / 10);
    r.lsb = 4'(n % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_hms_register.sv
// hh:mm:ss + pm BCD register: cascaded tick advance, or per-field increments without carry.
module bcd_hms_register
  import alarm_pkg::*;
#(
  parameter bit HOUR_24 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] hour_msb,
  output logic [3:0] hour_lsb,
  output logic [3:0] min_msb,
  output logic [3:0] min_lsb,
  output logic [3:0] sec_msb,
  output logic [3:0] sec_lsb,
  output logic       pm
);

  logic [7:0] sec_reg, sec_next, min_reg, min_next, hour_reg, hour_next;
  logic       pm_reg, pm_next;
  bcd_pair_t  sec_inc, min_inc, hour_inc;

  // Field increments take priority over the tick; the caller drops the tick when they collide
  always_comb begin
    sec_inc   = bcd_inc60(sec_reg[7:4], sec_reg[3:0]);
    min_inc   = bcd_inc60(min_reg[7:4], min_reg[3:0]);
    hour_inc  = bcd_inc_hour(HOUR_24, hour_reg[7:4], hour_reg[3:0]);
    sec_next  = sec_reg;
    min_next  = min_reg;
    hour_next = hour_reg;
    pm_next   = pm_reg;
    if (inc_sec || inc_min || inc_hour) begin
      if (inc_sec)  sec_next = {sec_inc.msb, sec_inc.lsb};
      if (inc_min)  min_next = {min_inc.msb, min_inc.lsb};
      if (inc_hour) begin
        hour_next = {hour_inc.msb, hour_inc.lsb};
        pm_next   = pm_reg ^ hour_inc.carry;
      end
    end else if (tick) begin
      sec_next = {sec_inc.msb, sec_inc.lsb};
      if (sec_inc.carry) begin
        min_next = {min_inc.msb, min_inc.lsb};
        if (min_inc.carry) begin
          hour_next = {hour_inc.msb, hour_inc.lsb};
          pm_next   = pm_reg ^ hour_inc.carry;
        end
      end
    end
  end

  // Digit registers; 12h mode resets to 12:00:00 AM
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_reg  <= 8'h00;
      min_reg  <= 8'h00;
      hour_reg <= HOUR_24 ? 8'h00 : {RST12_HOUR_MSB, RST12_HOUR_LSB};
      pm_reg   <= 1'b0;
    end else begin
      sec_reg  <= sec_next;
      min_reg  <= min_next;
      hour_reg <= hour_next;
      pm_reg   <= pm_next;
    end
  end

  assign hour_msb = hour_reg[7:4];
  assign hour_lsb = hour_reg[3:0];
  assign min_msb  = min_reg[7:4];
  assign min_lsb  = min_reg[3:0];
  assign sec_msb  = sec_reg[7:4];
  assign sec_lsb  = sec_reg[3:0];
  assign pm       = pm_reg;

endmodule

// File: rtl/alarm_clock_core.sv
// Alarm clock core: button edge detection, set/tick arbitration, alarm match and ring FSM.
module alarm_clock_core
  import alarm_pkg::*;
#(
  parameter bit HOUR_24    = 1'b1,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       sel_alarm,
  input  logic       upsec,
  input  logic       upmin,
  input  logic       uphour,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [3:0] outhourMSB,
  output logic [3:0] outhourLSB,
  output logic [3:0] outminMSB,
  output logic [3:0] outminLSB,
  output logic [3:0] outsecMSB,
  output logic [3:0] outsecLSB,
  output logic [3:0] almhourMSB,
  output logic [3:0] almhourLSB,
  output logic [3:0] almminMSB,
  output logic [3:0] almminLSB,
  output logic [3:0] almsecMSB,
  output logic [3:0] almsecLSB,
  output logic       pm,
  output logic       alm_pm,
  output logic       ring
);

  localparam int RING_W = $clog2(RING_SEC + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SEC);

  // Button bit order: 0 sec, 1 min, 2 hour, 3 snooze, 4 stop
  logic [4:0] btn_lvl, btn_prev_reg, btn_evt;
  assign btn_lvl = {stop, snooze, uphour, upmin, upsec};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_edge
      assign btn_evt[gi] = btn_lvl[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  logic time_set_any, time_tick, tick_applied_reg, match;
  assign time_set_any = (|btn_evt[2:0]) & ~sel_alarm;
  assign time_tick    = tick & ~time_set_any;

  bcd_hms_register #(.HOUR_24(HOUR_24)) u_time (
    .clk(clk), .reset(reset), .tick(time_tick),
    .inc_sec(btn_evt[0] & ~sel_alarm), .inc_min(btn_evt[1] & ~sel_alarm),
    .inc_hour(btn_evt[2] & ~sel_alarm),
    .hour_msb(outhourMSB), .hour_lsb(outhourLSB), .min_msb(outminMSB),
    .min_lsb(outminLSB), .sec_msb(outsecMSB), .sec_lsb(outsecLSB), .pm(pm)
  );

  bcd_hms_register #(.HOUR_24(HOUR_24)) u_alarm (
    .clk(clk), .reset(reset), .tick(1'b0),
    .inc_sec(btn_evt[0] & sel_alarm), .inc_min(btn_evt[1] & sel_alarm),
    .inc_hour(btn_evt[2] & sel_alarm),
    .hour_msb(almhourMSB), .hour_lsb(almhourLSB), .min_msb(almminMSB),
    .min_lsb(almminLSB), .sec_msb(almsecMSB), .sec_lsb(almsecLSB), .pm(alm_pm)
  );

  // Only a tick-driven update can match, so the compare waits one cycle for the new time
  assign match = tick_applied_reg &&
                 ({outhourMSB, outhourLSB, outminMSB, outminLSB, outsecMSB, outsecLSB, pm} ==
                  {almhourMSB, almhourLSB, almminMSB, almminLSB, almsecMSB, almsecLSB, alm_pm});

  alarm_state_t      state_reg, state_next;
  logic [RING_W-1:0] ring_cnt_reg, ring_cnt_next;
  logic [SNZ_W-1:0]  snz_cnt_reg, snz_cnt_next;
  logic              ring_reg;

  // Ring FSM next state; disarming overrides everything, stop beats snooze
  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    if (!alarm_en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (match) begin
            state_next    = RINGING;
            ring_cnt_next = RING_LOAD;
          end
        end
        RINGING: begin
          if (btn_evt[4]) begin
            state_next = IDLE;
          end else if (btn_evt[3]) begin
            state_next   = SNOOZED;
            snz_cnt_next = SNZ_LOAD;
          end else if (tick) begin
            if (ring_cnt_reg <= RING_W'(1)) state_next = IDLE;
            else ring_cnt_next = ring_cnt_reg - RING_W'(1);
          end
        end
        SNOOZED: begin
          if (btn_evt[4]) begin
            state_next = IDLE;
          end else if (tick) begin
            if (snz_cnt_reg <= SNZ_W'(1)) begin
              state_next    = RINGING;
              ring_cnt_next = RING_LOAD;
            end else begin
              snz_cnt_next = snz_cnt_reg - SNZ_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, counters, edge history and the registered ring output
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      ring_cnt_reg     <= '0;
      snz_cnt_reg      <= '0;
      ring_reg         <= 1'b0;
      btn_prev_reg     <= '0;
      tick_applied_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ring_cnt_reg     <= ring_cnt_next;
      snz_cnt_reg      <= snz_cnt_next;
      ring_reg         <= (state_next == RINGING);
      btn_prev_reg     <= btn_lvl;
      tick_applied_reg <= time_tick;
    end
  end

  assign ring = ring_reg;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed bench: 24h core (short ring/snooze) and 12h core driven side by side.
module tb_alarm_clock_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 24h instance "a": button bits 0 sec, 1 min, 2 hour, 3 snooze, 4 stop
  logic       a_tick = 0, a_sel = 0, a_en = 0;
  logic [4:0] a_btn = '0;
  logic [3:0] a_t [6];
  logic [3:0] a_al [6];
  logic       a_pm, a_alm_pm, a_ring;

  // 12h instance "b"
  logic       b_tick = 0, b_sel = 0, b_en = 0;
  logic [4:0] b_btn = '0;
  logic [3:0] b_t [6];
  logic [3:0] b_al [6];
  logic       b_pm, b_alm_pm, b_ring;

  int checks = 0;
  int errors = 0;

  alarm_clock_core #(.HOUR_24(1'b1), .RING_SEC(3), .SNOOZE_SEC(2)) dut_a (
    .clk(clk), .reset(reset), .tick(a_tick), .sel_alarm(a_sel),
    .upsec(a_btn[0]), .upmin(a_btn[1]), .uphour(a_btn[2]), .alarm_en(a_en),
    .snooze(a_btn[3]), .stop(a_btn[4]),
    .outhourMSB(a_t[0]), .outhourLSB(a_t[1]), .outminMSB(a_t[2]),
    .outminLSB(a_t[3]), .outsecMSB(a_t[4]), .outsecLSB(a_t[5]),
    .almhourMSB(a_al[0]), .almhourLSB(a_al[1]), .almminMSB(a_al[2]),
    .almminLSB(a_al[3]), .almsecMSB(a_al[4]), .almsecLSB(a_al[5]),
    .pm(a_pm), .alm_pm(a_alm_pm), .ring(a_ring)
  );

  alarm_clock_core #(.HOUR_24(1'b0)) dut_b (
    .clk(clk), .reset(reset), .tick(b_tick), .sel_alarm(b_sel),
    .upsec(b_btn[0]), .upmin(b_btn[1]), .uphour(b_btn[2]), .alarm_en(b_en),
    .snooze(b_btn[3]), .stop(b_btn[4]),
    .outhourMSB(b_t[0]), .outhourLSB(b_t[1]), .outminMSB(b_t[2]),
    .outminLSB(b_t[3]), .outsecMSB(b_t[4]), .outsecLSB(b_t[5]),
    .almhourMSB(b_al[0]), .almhourLSB(b_al[1]), .almminMSB(b_al[2]),
    .almminLSB(b_al[3]), .almsecMSB(b_al[4]), .almsecLSB(b_al[5]),
    .pm(b_pm), .alm_pm(b_alm_pm), .ring(b_ring)
  );

  function automatic logic [31:0] a_time();
    return {8'h0, a_t[0], a_t[1], a_t[2], a_t[3], a_t[4], a_t[5]};
  endfunction
  function automatic logic [31:0] a_alarm();
    return {8'h0, a_al[0], a_al[1], a_al[2], a_al[3], a_al[4], a_al[5]};
  endfunction
  function automatic logic [31:0] b_time();
    return {8'h0, b_t[0], b_t[1], b_t[2], b_t[3], b_t[4], b_t[5]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    $display("[%0t] check %-16s observed %h expected %h", $time, tag, obs, exp_v);
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic press_a(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      a_btn[idx] = 1'b1; cyc();
      a_btn[idx] = 1'b0; cyc();
    end
  endtask

  task automatic press_b(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      b_btn[idx] = 1'b1; cyc();
      b_btn[idx] = 1'b0; cyc();
    end
  endtask

  // One tick pulse followed by one idle cycle
  task automatic tick_a();
    a_tick = 1'b1; cyc();
    a_tick = 1'b0; cyc();
  endtask

  initial begin
    // Reset both cores
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    check("a_rst_time", a_time(), 32'h000000);
    check("a_rst_alarm", a_alarm(), 32'h000000);
    check("a_rst_flags", {29'h0, a_pm, a_alm_pm, a_ring}, 32'h0);
    check("b_rst_time", b_time(), 32'h120000);
    check("b_rst_pm", {31'h0, b_pm}, 32'h0);

    // 24h: set 23:59:59 without carries, then one tick wraps to midnight
    press_a(2, 23); press_a(1, 59); press_a(0, 59);
    check("a_set_235959", a_time(), 32'h235959);
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    check("a_tick_wrap", a_time(), 32'h000000);
    cyc();

    // 12h: 11:59:59 AM -> 12:00:00 PM
    press_b(2, 11); press_b(1, 59); press_b(0, 59);
    check("b_set_115959", {b_time()[23:0], 7'h0, b_pm}, {24'h115959, 8'h00});
    b_tick = 1'b1; cyc(); b_tick = 1'b0;
    check("b_tick_noon", {b_time()[23:0], 7'h0, b_pm}, {24'h120000, 8'h01});
    cyc();
    // 12:59:59 PM -> 01:00:00 PM
    press_b(1, 59); press_b(0, 59);
    b_tick = 1'b1; cyc(); b_tick = 1'b0;
    check("b_tick_1pm", {b_time()[23:0], 7'h0, b_pm}, {24'h010000, 8'h01});
    cyc();
    // Setting 11 -> 12 toggles pm back to 0
    press_b(2, 10);
    check("b_set_11", {b_time()[23:0], 7'h0, b_pm}, {24'h110000, 8'h01});
    press_b(2, 1);
    check("b_set_12_pm", {b_time()[23:0], 7'h0, b_pm}, {24'h120000, 8'h00});

    // 24h: 10:59:30, holding upmin gives exactly one no-carry increment
    press_a(2, 10); press_a(1, 59); press_a(0, 30);
    check("a_set_105930", a_time(), 32'h105930);
    a_btn[1] = 1'b1;
    repeat (5) cyc();
    a_btn[1] = 1'b0; cyc();
    check("a_hold_upmin", a_time(), 32'h100030);
    // Time set coincident with tick: set wins, tick dropped
    a_btn[1] = 1'b1; a_tick = 1'b1; cyc();
    a_btn[1] = 1'b0; a_tick = 1'b0; cyc();
    check("a_set_vs_tick", a_time(), 32'h100130);
    // Alarm set coincident with tick: both apply
    a_sel = 1'b1;
    a_btn[0] = 1'b1; a_tick = 1'b1; cyc();
    a_btn[0] = 1'b0; a_tick = 1'b0; cyc();
    a_sel = 1'b0;
    check("a_alm_tick_time", a_time(), 32'h100131);
    check("a_alm_tick_alarm", a_alarm(), 32'h000001);

    // Fresh start for the alarm sequence
    reset = 1'b0; cyc(); reset = 1'b1;
    check("a_rst2_alarm", a_alarm(), 32'h000000);
    a_sel = 1'b1; press_a(2, 7); a_sel = 1'b0;
    check("a_alarm_0700", a_alarm(), 32'h070000);
    press_a(2, 6); press_a(1, 59); press_a(0, 59);
    a_en = 1'b1;
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    check("a_match_time", a_time(), 32'h070000);
    check("a_ring_not_yet", {31'h0, a_ring}, 32'h0);
    cyc();
    check("a_ring_rise", {31'h0, a_ring}, 32'h1);
    // Three ticks of ringing, then auto-stop
    tick_a(); tick_a();
    check("a_ring_2ticks", {31'h0, a_ring}, 32'h1);
    tick_a();
    check("a_ring_autostop", {31'h0, a_ring}, 32'h0);

    // Re-arm at 07:00:04, ring, snooze for two ticks
    a_sel = 1'b1; press_a(0, 4); a_sel = 1'b0;
    tick_a();
    check("a_ring_again", {31'h0, a_ring}, 32'h1);
    press_a(3, 1);
    check("a_snoozed", {31'h0, a_ring}, 32'h0);
    tick_a();
    check("a_snooze_1tick", {31'h0, a_ring}, 32'h0);
    press_a(3, 1);
    tick_a();
    check("a_snooze_expire", {31'h0, a_ring}, 32'h1);
    // stop and snooze together: stop wins, so no re-ring after two ticks
    a_btn[4] = 1'b1; a_btn[3] = 1'b1; cyc();
    a_btn[4] = 1'b0; a_btn[3] = 1'b0; cyc();
    check("a_stop_wins", {31'h0, a_ring}, 32'h0);
    tick_a(); tick_a();
    check("a_stop_idle", {31'h0, a_ring}, 32'h0);
    check("a_time_070008", a_time(), 32'h070008);

    // Ring at 07:00:09, then disarm
    a_sel = 1'b1; press_a(0, 5); a_sel = 1'b0;
    tick_a();
    check("a_ring_0709", {31'h0, a_ring}, 32'h1);
    a_en = 1'b0; cyc();
    check("a_disarm", {31'h0, a_ring}, 32'h0);
    a_en = 1'b1; cyc();
    check("a_rearm_quiet", {31'h0, a_ring}, 32'h0);

    // Ring at 07:00:10, snooze, then reset mid-snooze
    a_sel = 1'b1; press_a(0, 1); a_sel = 1'b0;
    tick_a();
    check("a_ring_0710", {31'h0, a_ring}, 32'h1);
    press_a(3, 1);
    reset = 1'b0; cyc(); reset = 1'b1;
    check("a_rst_snz_time", a_time(), 32'h000000);
    check("a_rst_snz_alarm", a_alarm(), 32'h000000);
    check("a_rst_snz_ring", {31'h0, a_ring}, 32'h0);
    tick_a(); tick_a();
    check("a_rst_snz_idle", {31'h0, a_ring}, 32'h0);
    check("a_rst_snz_tick", a_time(), 32'h000002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
